// File: rtl/tff_pkg.sv
// Shared mode encoding for the flip-flop bank.
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_T  = 2'b00,
    MODE_D  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

endpackage : tff_pkg

// File: rtl/tff_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module tff_popcount #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PC_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [PC_W-1:0]  o_cnt_c
);

  // Sum the set bits one at a time.
  always_comb begin
    o_cnt_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_cnt_c = o_cnt_c + PC_W'(i_vec[i]);
    end
  end

endmodule : tff_popcount

// File: rtl/tff_bank.sv
// Bank of WIDTH flip-flop channels sharing a run-time T/D/JK/SR mode,
// with parallel load, per-channel flip pulses, a saturating flip counter
// and a sticky SR-illegal flag.
module tff_bank
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr_cnt,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic [WIDTH-1:0] o_flip,
  output logic [CNT_W-1:0] o_flip_cnt,
  output logic             o_sr_err
);

  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_flip;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [WIDTH-1:0] w_q_mode;
  logic [WIDTH-1:0] w_q_op;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH-1:0] w_flip_nx;
  logic [PC_W-1:0]  w_pc;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_err_now;
  logic             w_err_nx;

  // Per-mode next value ignoring enable; SR 11 falls through to hold.
  always_comb begin
    w_q_mode = r_q;
    case (i_mode)
      MODE_T:  w_q_mode = r_q ^ i_a;
      MODE_D:  w_q_mode = i_a;
      MODE_JK: w_q_mode = (i_a & ~r_q) | (~i_b & r_q);
      MODE_SR: w_q_mode = (i_a & ~i_b) | (r_q & ~(i_a ^ i_b));
      default: w_q_mode = r_q;
    endcase
  end

  // Apply enable mask, load priority and derive flip pulses.
  always_comb begin
    w_q_op    = (w_q_mode & i_en) | (r_q & ~i_en);
    w_q_nx    = i_load ? i_load_val : w_q_op;
    w_flip_nx = i_load ? '0 : (w_q_op ^ r_q);
  end

  tff_popcount #(.WIDTH(WIDTH)) u_popcount (
    .i_vec   (w_flip_nx),
    .o_cnt_c (w_pc)
  );

  // Clear-then-add saturating counter and sticky SR error flag.
  always_comb begin
    w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pc);
    w_cnt_nx  = (w_sum > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
    if (i_clr_cnt) begin
      w_cnt_nx = CNT_W'(w_pc);
    end
    w_err_now = (i_mode == MODE_SR) && !i_load && |(i_en & i_a & i_b);
    w_err_nx  = (i_clr_cnt ? 1'b0 : r_err) | w_err_now;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_flip <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_q    <= w_q_nx;
      r_flip <= w_flip_nx;
      r_cnt  <= w_cnt_nx;
      r_err  <= w_err_nx;
    end
  end

  assign o_q        = r_q;
  assign o_qbar     = ~r_q;
  assign o_flip     = r_flip;
  assign o_flip_cnt = r_cnt;
  assign o_sr_err   = r_err;

endmodule : tff_bank

// File: tb/tb_tff_bank.sv
// Directed self-checking bench for tff_bank; a second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_tff_bank;
  import tff_pkg::*;

  logic       clk;
  logic       rst;
  mode_t      mode;
  logic [7:0] en, a, b, load_val;
  logic       load, clr_cnt;

  logic [7:0] q, qbar, flip, cnt;
  logic       err;
  logic [7:0] q_s, qbar_s, flip_s;
  logic [3:0] cnt_s;
  logic       err_s;

  int checks   = 0;
  int failures = 0;

  tff_bank #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
    .i_load(load), .i_load_val(load_val), .i_clr_cnt(clr_cnt),
    .o_q(q), .o_qbar(qbar), .o_flip(flip), .o_flip_cnt(cnt), .o_sr_err(err)
  );

  tff_bank #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .i_mode(mode), .i_en(en), .i_a(a), .i_b(b),
    .i_load(load), .i_load_val(load_val), .i_clr_cnt(clr_cnt),
    .o_q(q_s), .o_qbar(qbar_s), .o_flip(flip_s), .o_flip_cnt(cnt_s), .o_sr_err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_T; en = 8'h00; a = 8'h00; b = 8'h00;
    load = 1'b0; load_val = 8'h00; clr_cnt = 1'b0;

    // Reset
    step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(qbar), 32'hFF);
    chk("rst_flip", 32'(flip), 32'h00);
    chk("rst_cnt", 32'(cnt), 32'h00);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_qbar_s", 32'(qbar_s), 32'hFF);

    // T toggle, three edges
    rst = 1'b0; mode = MODE_T; en = 8'hFF; a = 8'h0F;
    step();
    chk("t1_q", 32'(q), 32'h0F);
    chk("t1_qbar", 32'(qbar), 32'hF0);
    chk("t1_flip", 32'(flip), 32'h0F);
    chk("t1_cnt", 32'(cnt), 32'd4);
    step();
    chk("t2_q", 32'(q), 32'h00);
    chk("t2_flip", 32'(flip), 32'h0F);
    chk("t2_cnt", 32'(cnt), 32'd8);
    step();
    chk("t3_q", 32'(q), 32'h0F);
    chk("t3_cnt", 32'(cnt), 32'd12);
    chk("t3_cnt_s", 32'(cnt_s), 32'd12);

    // clr_cnt with a T operation flipping 3 channels: 0F^07 = 08
    clr_cnt = 1'b1; a = 8'h07;
    step();
    chk("clr_q", 32'(q), 32'h08);
    chk("clr_cnt", 32'(cnt), 32'd3);
    chk("clr_cnt_s", 32'(cnt_s), 32'd3);

    // Load AA
    clr_cnt = 1'b0; load = 1'b1; load_val = 8'hAA;
    step();
    chk("ldaa_q", 32'(q), 32'hAA);
    chk("ldaa_flip", 32'(flip), 32'h00);
    chk("ldaa_cnt", 32'(cnt), 32'd3);

    // JK from AA, J=F0 K=CC: 7,6 toggle; 5,4 set; 3,2 reset; 1,0 hold -> 72
    load = 1'b0; mode = MODE_JK; a = 8'hF0; b = 8'hCC;
    step();
    chk("jk_q", 32'(q), 32'h72);
    chk("jk_flip", 32'(flip), 32'hD8);
    chk("jk_cnt", 32'(cnt), 32'd7);

    // SR 11 on channel 0: hold and raise error
    mode = MODE_SR; a = 8'h01; b = 8'h01;
    step();
    chk("sr_q", 32'(q), 32'h72);
    chk("sr_flip", 32'(flip), 32'h00);
    chk("sr_err", 32'(err), 32'h1);
    chk("sr_cnt", 32'(cnt), 32'd7);

    // D with lower-nibble enable: 72 -> 7F, flips 0D
    mode = MODE_D; en = 8'h0F; a = 8'hFF; b = 8'h00;
    step();
    chk("den_q", 32'(q), 32'h7F);
    chk("den_flip", 32'(flip), 32'h0D);
    chk("den_cnt", 32'(cnt), 32'd10);
    chk("den_err", 32'(err), 32'h1);

    // Load beats the D operation
    load = 1'b1; load_val = 8'h3C; a = 8'h00;
    step();
    chk("ld3c_q", 32'(q), 32'h3C);
    chk("ld3c_flip", 32'(flip), 32'h00);
    chk("ld3c_cnt", 32'(cnt), 32'd10);

    // clr_cnt together with a new SR error: error wins
    load = 1'b0; mode = MODE_SR; en = 8'hFF; a = 8'h01; b = 8'h01; clr_cnt = 1'b1;
    step();
    chk("clrsr_q", 32'(q), 32'h3C);
    chk("clrsr_cnt", 32'(cnt), 32'd0);
    chk("clrsr_err", 32'(err), 32'h1);

    // Saturation: 4-bit counter 0 -> 8 -> 15 -> 15
    clr_cnt = 1'b0; mode = MODE_T; en = 8'hFF; a = 8'hFF; b = 8'h00;
    step();
    chk("sat1_q_s", 32'(q_s), 32'hC3);
    chk("sat1_flip_s", 32'(flip_s), 32'hFF);
    chk("sat1_cnt_s", 32'(cnt_s), 32'd8);
    chk("sat1_cnt", 32'(cnt), 32'd8);
    step();
    chk("sat2_cnt_s", 32'(cnt_s), 32'd15);
    chk("sat2_cnt", 32'(cnt), 32'd16);
    step();
    chk("sat3_cnt_s", 32'(cnt_s), 32'd15);
    chk("sat3_q", 32'(q), 32'hC3);
    chk("sat3_err_s", 32'(err_s), 32'h1);

    // Build cnt=9, err=1: clear+toggle all (cnt 8), then SR set bit1 + illegal bit0
    clr_cnt = 1'b1;
    step();
    chk("pre1_q", 32'(q), 32'h3C);
    chk("pre1_cnt", 32'(cnt), 32'd8);
    chk("pre1_err", 32'(err), 32'h0);
    clr_cnt = 1'b0; mode = MODE_SR; a = 8'h03; b = 8'h01;
    step();
    chk("pre2_q", 32'(q), 32'h3E);
    chk("pre2_cnt", 32'(cnt), 32'd9);
    chk("pre2_err", 32'(err), 32'h1);

    // Reset overrides load and toggle
    rst = 1'b1; load = 1'b1; load_val = 8'hFF; mode = MODE_T; a = 8'hFF; b = 8'h00;
    step();
    chk("mrst_q", 32'(q), 32'h00);
    chk("mrst_qbar", 32'(qbar), 32'hFF);
    chk("mrst_flip", 32'(flip), 32'h00);
    chk("mrst_cnt", 32'(cnt), 32'd0);
    chk("mrst_err", 32'(err), 32'h0);
    chk("mrst_cnt_s", 32'(cnt_s), 32'd0);

    // Idle hold after reset
    rst = 1'b0; load = 1'b0; a = 8'h00;
    step();
    chk("idle_q", 32'(q), 32'h00);
    chk("idle_flip", 32'(flip), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tff_bank
